// File: rtl/zoom_hdmi_fifo_rd_sched.sv
// ---------------------------------------------------------------------------
// zoom_hdmi_fifo_rd_sched
//
// Read-side scheduler for the zoom->HDMI distributed FIFO, running in the
// HDMI pixel clock domain. For each line_req pulse it waits until the FIFO
// holds at least PREFILL_LVL words, then reads exactly LINE_WORDS words.
// While reading it never reads an empty FIFO, and it stalls instead. Read
// data is re-timed into a pix_data/pix_vld stream. The block also counts
// lines per frame and flags underflow and missed-line errors.
//
// Ports
//   rd_clk         pixel clock (rising edge)
//   rd_rst         synchronous active-high reset
//   frame_start    1-cycle frame start pulse; aborts any line in progress
//   line_req       1-cycle request for the next line
//   clear_err      clears the sticky error flags and underflow_cnt
//   fifo_empty     FIFO empty flag
//   fifo_rd_level  FIFO read water level (ADDR_WIDTH+1 bits)
//   fifo_rd_data   FIFO read data
//   fifo_rd_en     FIFO read enable (combinational: READ state and not empty)
//   pix_data       registered pixel word
//   pix_vld        pix_data valid (rd_en delayed by 1+OUT_REG cycles)
//   line_busy      a line is in progress (PREFILL or READ)
//   line_cnt       lines completed in the current frame
//   frame_done     1-cycle pulse after the last line of a frame
//   underflow      sticky: FIFO was empty during READ
//   missed_line    sticky: line_req arrived while a line was in progress
//   underflow_cnt  stall cycles, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module zoom_hdmi_fifo_rd_sched #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 240,
    parameter int OUT_REG         = 0,
    parameter int LINE_WORDS      = 8,
    parameter int PREFILL_LVL     = 4,
    parameter int LINES_PER_FRAME = 1080
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  frame_start,
    input  logic                  line_req,
    input  logic                  clear_err,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_level,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_vld,
    output logic                  line_busy,
    output logic [11:0]           line_cnt,
    output logic                  frame_done,
    output logic                  underflow,
    output logic                  missed_line,
    output logic [15:0]           underflow_cnt
);

    // A 1-bit counter is kept even for LINE_WORDS == 1 so the vector is legal.
    localparam int WCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [WCW-1:0]      LAST_WORD   = WCW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] PREFILL_THR = (ADDR_WIDTH + 1)'(PREFILL_LVL);
    localparam logic [11:0]         LAST_LINE   = 12'(LINES_PER_FRAME);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PREFILL,
        S_READ
    } state_t;

    state_t                  r_state;
    logic [WCW-1:0]          r_word_cnt;
    logic [11:0]             r_line_cnt;
    logic                    r_frame_done;
    logic                    r_underflow;
    logic                    r_missed_line;
    logic [15:0]             r_underflow_cnt;
    logic                    r_pix_vld;
    logic [DATA_WIDTH-1:0]   r_pix_data;

    logic                    w_rd_en;
    logic                    w_uf_evt;
    logic                    w_ml_evt;
    logic                    w_busy;
    logic                    w_cap;
    logic [11:0]             w_line_cnt_inc;

    assign w_busy         = (r_state == S_PREFILL) || (r_state == S_READ);
    assign w_rd_en        = (r_state == S_READ) && !fifo_empty;
    assign w_uf_evt       = (r_state == S_READ) && fifo_empty;
    // A request coinciding with frame_start is consumed as line 0, not missed.
    assign w_ml_evt       = line_req && !frame_start && w_busy;
    assign w_line_cnt_inc = r_line_cnt + 12'd1;

    // ---------------------------------------------------------------------
    // Line / frame sequencing
    // ---------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_line_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (frame_start) begin
                // Abort whatever is in progress; the FIFO itself is untouched.
                r_line_cnt <= '0;
                r_word_cnt <= '0;
                r_state    <= line_req ? S_PREFILL : S_ARMED;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // line_req is deliberately ignored until a frame starts
                    end
                    S_ARMED: begin
                        if (line_req) begin
                            r_word_cnt <= '0;
                            r_state    <= S_PREFILL;
                        end
                    end
                    S_PREFILL: begin
                        if (fifo_rd_level >= PREFILL_THR) begin
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (w_rd_en) begin
                            if (r_word_cnt == LAST_WORD) begin
                                r_word_cnt <= '0;
                                r_line_cnt <= w_line_cnt_inc;
                                if (w_line_cnt_inc == LAST_LINE) begin
                                    r_frame_done <= 1'b1;
                                    r_state      <= S_IDLE;
                                end else begin
                                    r_state <= S_ARMED;
                                end
                            end else begin
                                r_word_cnt <= r_word_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Error reporting. A fresh event in the same cycle as clear_err survives.
    // ---------------------------------------------------------------------
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_underflow     <= 1'b0;
            r_missed_line   <= 1'b0;
            r_underflow_cnt <= '0;
        end else if (clear_err) begin
            r_underflow     <= w_uf_evt;
            r_missed_line   <= w_ml_evt;
            r_underflow_cnt <= w_uf_evt ? 16'd1 : 16'd0;
        end else begin
            if (w_uf_evt) begin
                r_underflow <= 1'b1;
                if (r_underflow_cnt != 16'hFFFF) begin
                    r_underflow_cnt <= r_underflow_cnt + 16'd1;
                end
            end
            if (w_ml_evt) begin
                r_missed_line <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Data path. With OUT_REG=0 the FIFO word is visible in the rd_en cycle;
    // with OUT_REG=1 it appears one cycle later. w_cap marks the cycle in
    // which fifo_rd_data holds a word that was read.
    // ---------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic r_rd_dly;
            always_ff @(posedge rd_clk) begin
                if (rd_rst) begin
                    r_rd_dly <= 1'b0;
                end else begin
                    r_rd_dly <= w_rd_en;
                end
            end
            assign w_cap = r_rd_dly;
        end else begin : g_no_out_reg
            assign w_cap = w_rd_en;
        end
    endgenerate

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_pix_vld  <= 1'b0;
            r_pix_data <= '0;
        end else begin
            r_pix_vld <= w_cap;
            if (w_cap) begin
                r_pix_data <= fifo_rd_data;
            end
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign pix_data      = r_pix_data;
    assign pix_vld       = r_pix_vld;
    assign line_busy     = w_busy;
    assign line_cnt      = r_line_cnt;
    assign frame_done    = r_frame_done;
    assign underflow     = r_underflow;
    assign missed_line   = r_missed_line;
    assign underflow_cnt = r_underflow_cnt;

endmodule
